// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode: circular buffer of {pc, instr} pairs with a
// valid/ready handshake on both sides and a single-cycle flush for redirects.
module fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PTR_W     = 2,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  input  logic [15:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_instr,
  output logic [15:0]      out_pc,
  output logic [PTR_W:0]   count,
  output logic             err
);

  localparam logic [PTR_W:0] Full = (PTR_W + 1)'(DEPTH);

  logic [31:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_err;

  logic             w_push;
  logic             w_pop;
  logic [PTR_W:0]   w_count_d;

  // in_ready depends only on registered occupancy, so a pop never frees a slot same-cycle
  assign in_ready  = (r_count != Full);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_instr = out_valid ? r_mem[r_rd_ptr][15:0]  : NOP_INSTR;
  assign out_pc    = out_valid ? r_mem[r_rd_ptr][31:16] : 16'h0000;
  assign count     = r_count;
  assign err       = r_err;

  always_comb begin
    w_count_d = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + (PTR_W + 1)'(1);
      2'b01:   w_count_d = r_count - (PTR_W + 1)'(1);
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_mem[r_wr_ptr] <= {in_pc, in_instr};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      // Occupancy above DEPTH can only come from corrupted state; latch it as an error
      if ((w_push && !flush && in_pc[0]) || (r_count > Full)) begin
        r_err <= 1'b1;
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_count <= w_count_d;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam logic [15:0] NOP   = 16'h0800;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_instr;
  logic [15:0]      in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_instr;
  logic [15:0]      out_pc;
  logic [PTR_W:0]   count;
  logic             err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0] m_q [$];
  logic        m_err;

  fetch_queue #(
    .DEPTH     (DEPTH),
    .PTR_W     (PTR_W),
    .NOP_INSTR (NOP)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .count     (count),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned n;
    n = m_q.size();
    check_eq({tag, ".count"},     32'(count),     32'(n));
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(n != 0));
    check_eq({tag, ".in_ready"},  32'(in_ready),  32'(n != DEPTH));
    check_eq({tag, ".out_instr"}, 32'(out_instr), (n != 0) ? 32'(m_q[0][15:0]) : 32'(NOP));
    check_eq({tag, ".out_pc"},    32'(out_pc),    (n != 0) ? 32'(m_q[0][31:16]) : 32'h0);
    check_eq({tag, ".err"},       32'(err),       32'(m_err));
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model across the edge
  task automatic step(input string tag, input logic f, input logic iv, input logic [15:0] pc,
                      input logic [15:0] ins, input logic ordy);
    logic push;
    logic pop;
    flush     = f;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    @(negedge clk);
    check_all(tag);
    push = iv && (m_q.size() != DEPTH);
    pop  = ordy && (m_q.size() != 0);
    if (f) begin
      m_q.delete();
    end else begin
      if (push && pc[0]) m_err = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back({pc, ins});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_q.delete();
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [15:0] pc;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; out_ready = 1'b0;
    m_err = 1'b0;

    // Reset then idle
    do_reset();
    @(negedge clk);
    check_eq("reset.count", 32'(count), 32'h0);
    check_eq("reset.out_valid", 32'(out_valid), 32'h0);
    check_eq("reset.in_ready", 32'(in_ready), 32'h1);
    check_eq("reset.out_instr", 32'(out_instr), 32'h0800);
    check_eq("reset.out_pc", 32'(out_pc), 32'h0);
    check_eq("reset.err", 32'(err), 32'h0);
    @(posedge clk); #1;

    // Fill, refuse a fifth, drain in order
    for (int i = 0; i < 4; i++) step("fill", 1'b0, 1'b1, 16'(2 * i), 16'hA001 + 16'(i), 1'b0);
    step("full", 1'b0, 1'b1, 16'h0008, 16'hA005, 1'b0);
    check_eq("full.count", 32'(count), 32'd4);
    for (int i = 0; i < 5; i++) step("drain", 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    check_eq("drain.out_valid", 32'(out_valid), 32'h0);

    // Steady-state streaming at count=2
    pc = 16'h0010;
    for (int i = 0; i < 2; i++) begin
      step("prime", 1'b0, 1'b1, pc, 16'hC000 + pc, 1'b0);
      pc += 16'd2;
    end
    for (int i = 0; i < 10; i++) begin
      step("stream", 1'b0, 1'b1, pc, 16'hC000 + pc, 1'b1);
      pc += 16'd2;
    end
    check_eq("stream.count", 32'(count), 32'd2);

    // Flush with concurrent traffic at count=3
    step("pre_flush", 1'b0, 1'b1, pc, 16'hC000 + pc, 1'b0);
    step("flush", 1'b1, 1'b1, 16'h0200, 16'hDEAD, 1'b1);
    step("post_flush", 1'b0, 1'b1, 16'h0100, 16'hB000, 1'b0);
    step("head", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check_eq("flush.head_pc", 32'(out_pc), 32'h0100);

    // Misaligned PC sets sticky err that survives flush
    step("misalign", 1'b0, 1'b1, 16'h0003, 16'h1234, 1'b0);
    step("err_seen", 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    step("err_kept", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check_eq("err.sticky", 32'(err), 32'h1);
    do_reset();
    step("err_clr", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

    // Asynchronous reset mid-stream, between edges
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b0, 1'b1, 16'(4 * i), 16'h7000, 1'b0);
    check_eq("pre_rst.count", 32'(count), 32'd3);
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_eq("async.count", 32'(count), 32'h0);
    check_eq("async.out_valid", 32'(out_valid), 32'h0);
    check_eq("async.in_ready", 32'(in_ready), 32'h1);
    m_q.delete();
    m_err = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Randomized traffic with aligned PCs and occasional flushes
    for (int i = 0; i < 2000; i++) begin
      pc = 16'($urandom) & 16'hFFFE;
      step("rand", ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), pc,
           16'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
